tsdn28hpcpa_4096x32_m8m: RTL and testbench



---
 rtl/tsdn28hpcpa_4096x32_m8m.sv | 70 +++++++
 tb/tb_tsdn28hpcpa_4096x32_m8m.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tsdn28hpcpa_4096x32_m8m.sv
// Behavioral 4096x32 dual-port synchronous SRAM macro model.
// Active-low CEB/WEB per port, port A wins write collisions, read-before-write.
module tsdn28hpcpa_4096x32_m8m #(
  parameter int N = 32,
  parameter int M = 12
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [M-1:0] AA,
  input  logic [N-1:0] DA,
  input  logic         WEBA,
  input  logic         CEBA,
  output logic [N-1:0] QA,
  input  logic [M-1:0] AB,
  input  logic [N-1:0] DB,
  input  logic         WEBB,
  input  logic         CEBB,
  output logic [N-1:0] QB,
  input  logic [1:0]   WTSEL,
  input  logic [1:0]   RTSEL,
  input  logic         VG,
  input  logic         VS
);

  localparam int DEPTH = 1 << M;

  // Array powers up cleared; RST never touches it.
  logic [N-1:0] r_mem [DEPTH] = '{default: '0};
  logic [N-1:0] r_qa;
  logic [N-1:0] r_qb;

  logic w_pwr;
  logic w_wr_a;
  logic w_wr_b;
  logic w_rd_a;
  logic w_rd_b;
  logic w_unused;

  assign w_pwr    = VG & VS;
  assign w_wr_a   = ~CEBA & ~WEBA;
  assign w_wr_b   = ~CEBB & ~WEBB;
  assign w_rd_a   = ~CEBA &  WEBA;
  assign w_rd_b   = ~CEBB &  WEBB;
  assign w_unused = ^{WTSEL, RTSEL};

  // B is written first so a same-address A write overrides it.
  always_ff @(posedge CLK) begin
    if (!RST && w_pwr) begin
      if (w_wr_b) r_mem[AB] <= DB;
      if (w_wr_a) r_mem[AA] <= DA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_qa <= '0;
      r_qb <= '0;
    end else if (!w_pwr) begin
      r_qa <= '0;
      r_qb <= '0;
    end else begin
      if (w_rd_a) r_qa <= r_mem[AA];
      if (w_rd_b) r_qb <= r_mem[AB];
    end
  end

  assign QA = r_qa;
  assign QB = r_qb;

endmodule

// File: tb/tb_tsdn28hpcpa_4096x32_m8m.sv
// Directed self-checking bench for the 4096x32 dual-port SRAM model.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_tsdn28hpcpa_4096x32_m8m;

  logic        CLK;
  logic        RST;
  logic [11:0] AA, AB;
  logic [31:0] DA, DB;
  logic        WEBA, CEBA, WEBB, CEBB;
  logic [31:0] QA, QB;
  logic [1:0]  WTSEL, RTSEL;
  logic        VG, VS;

  int n_chk  = 0;
  int n_fail = 0;

  tsdn28hpcpa_4096x32_m8m #(.N(32), .M(12)) dut (
    .CLK(CLK), .RST(RST),
    .AA(AA), .DA(DA), .WEBA(WEBA), .CEBA(CEBA), .QA(QA),
    .AB(AB), .DB(DB), .WEBB(WEBB), .CEBB(CEBB), .QB(QB),
    .WTSEL(WTSEL), .RTSEL(RTSEL), .VG(VG), .VS(VS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // op: 0 idle, 1 read, 2 write
  task automatic opa(input int op, input logic [11:0] a,
                     input logic [31:0] d);
    CEBA = (op == 0);
    WEBA = (op != 2);
    AA   = a;
    DA   = d;
  endtask

  task automatic opb(input int op, input logic [11:0] a,
                     input logic [31:0] d);
    CEBB = (op == 0);
    WEBB = (op != 2);
    AB   = a;
    DB   = d;
  endtask

  task automatic idle();
    opa(0, 12'h0, 32'h0);
    opb(0, 12'h0, 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    WTSEL = 2'b01;
    RTSEL = 2'b01;
    VG = 1'b1;
    VS = 1'b1;
    idle();
    #2;
    check("rst_qa", QA, 32'h0);
    check("rst_qb", QB, 32'h0);
    cyc();
    cyc();
    RST = 1'b0;
    cyc();
    cyc();
    check("idle_qa", QA, 32'h0);
    check("idle_qb", QB, 32'h0);

    // Unwritten location reads zero on both ports
    opa(1, 12'h123, 32'h0);
    opb(1, 12'h555, 32'h0);
    cyc();
    check("zero_qa", QA, 32'h0);
    check("zero_qb", QB, 32'h0);

    // Basic write/read; QA must hold across its own write
    idle();
    opb(2, 12'h200, 32'h13572468);
    cyc();
    idle();
    opa(1, 12'h200, 32'h0);
    cyc();
    check("rd_200", QA, 32'h13572468);
    opa(2, 12'h123, 32'hDEADBEEF);
    cyc();
    check("wr_hold_qa", QA, 32'h13572468);
    idle();
    opb(1, 12'h123, 32'h0);
    cyc();
    check("rd_123_b", QB, 32'hDEADBEEF);

    // Write collision: A wins
    opa(2, 12'h7FF, 32'h11111111);
    opb(2, 12'h7FF, 32'h22222222);
    cyc();
    opa(1, 12'h7FF, 32'h0);
    opb(1, 12'h7FF, 32'h0);
    cyc();
    check("coll_qa", QA, 32'h11111111);
    check("coll_qb", QB, 32'h11111111);

    // Read-before-write, both directions
    idle();
    opa(2, 12'h010, 32'hAAAA5555);
    cyc();
    opa(1, 12'h010, 32'h0);
    opb(2, 12'h010, 32'h0F0F0F0F);
    cyc();
    check("rbw_a_old", QA, 32'hAAAA5555);
    idle();
    opa(1, 12'h010, 32'h0);
    cyc();
    check("rbw_a_new", QA, 32'h0F0F0F0F);
    opa(2, 12'h010, 32'h12345678);
    opb(1, 12'h010, 32'h0);
    cyc();
    check("rbw_b_old", QB, 32'h0F0F0F0F);
    idle();
    opb(1, 12'h010, 32'h0);
    cyc();
    check("rbw_b_new", QB, 32'h12345678);

    // Boundary addresses
    opa(2, 12'h000, 32'h00000001);
    opb(2, 12'hFFF, 32'h80000000);
    cyc();
    opa(1, 12'hFFF, 32'h0);
    opb(1, 12'h000, 32'h0);
    cyc();
    check("bnd_a_fff", QA, 32'h80000000);
    check("bnd_b_000", QB, 32'h00000001);
    opa(1, 12'h000, 32'h0);
    opb(1, 12'hFFF, 32'h0);
    cyc();
    check("bnd_a_000", QA, 32'h00000001);
    check("bnd_b_fff", QB, 32'h80000000);

    // Reset mid-operation
    idle();
    opa(2, 12'h400, 32'hCAFEF00D);
    cyc();
    opa(1, 12'h400, 32'h0);
    opb(1, 12'h400, 32'h0);
    cyc();
    check("pre_rst_qa", QA, 32'hCAFEF00D);
    check("pre_rst_qb", QB, 32'hCAFEF00D);
    idle();
    RST = 1'b1;
    #2;
    check("async_rst_qa", QA, 32'h0);
    check("async_rst_qb", QB, 32'h0);
    opa(2, 12'h400, 32'h0BADBAD0);
    opb(1, 12'h400, 32'h0);
    cyc();
    check("in_rst_qb", QB, 32'h0);
    RST = 1'b0;
    opa(1, 12'h400, 32'h0);
    opb(0, 12'h0, 32'h0);
    cyc();
    check("post_rst_qa", QA, 32'hCAFEF00D);

    // Power pins
    opa(2, 12'h001, 32'h600DCAFE);
    cyc();
    opa(1, 12'h001, 32'h0);
    opb(1, 12'h400, 32'h0);
    cyc();
    check("pwr_pre_qa", QA, 32'h600DCAFE);
    check("pwr_pre_qb", QB, 32'hCAFEF00D);
    VS = 1'b0;
    opa(2, 12'h001, 32'h5A5A5A5A);
    opb(0, 12'h0, 32'h0);
    cyc();
    check("vs0_qa", QA, 32'h0);
    check("vs0_qb", QB, 32'h0);
    VS = 1'b1;
    opa(1, 12'h001, 32'h0);
    cyc();
    check("vs1_qa", QA, 32'h600DCAFE);
    VG = 1'b0;
    opa(0, 12'h0, 32'h0);
    opb(2, 12'h001, 32'hFFFF0000);
    cyc();
    VG = 1'b1;
    opb(1, 12'h001, 32'h0);
    cyc();
    check("vg0_qb", QB, 32'h600DCAFE);
    idle();
    cyc();
    check("hold_qb", QB, 32'h600DCAFE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
